// File: rtl/cache_ctrl_wb.sv
// ============================================================================
// Module      : cache_ctrl_wb
// Description : Controller for a 2-way set-associative write-back cache.
//               Handles lookup, dirty write-back, refill, tag update, 1-bit LRU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_ctrl_wb #(
    parameter int ADDR_WIDTH   = 16,
    parameter int TAG_WIDTH    = 6,
    parameter int INDEX_WIDTH  = 8,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_rd,
    input  logic                    cpu_wr,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    output logic                    cpu_ready,
    output logic                    tag_rd,
    output logic [1:0]              tag_wr,
    output logic [INDEX_WIDTH-1:0]  tag_index,
    output logic [TAG_WIDTH-1:0]    tag_in,
    output logic                    dirty_wr,
    input  logic [TAG_WIDTH-1:0]    tagout0,
    input  logic [TAG_WIDTH-1:0]    tagout1,
    input  logic                    valid0,
    input  logic                    valid1,
    input  logic                    dirty0,
    input  logic                    dirty1,
    output logic                    data_way,
    output logic [OFFSET_WIDTH-1:0] data_offset,
    output logic                    data_wr,
    output logic                    data_src,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_ready
);

    localparam int                    c_SETS     = 1 << INDEX_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] c_CNT_LAST = '1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOOKUP = 3'd1;
    localparam logic [2:0] c_WB     = 3'd2;
    localparam logic [2:0] c_REFILL = 3'd3;
    localparam logic [2:0] c_UPDATE = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_req_addr;
    logic                    r_req_wr;
    logic                    r_victim;
    logic [OFFSET_WIDTH-1:0] r_cnt;
    logic [c_SETS-1:0]       r_lru;

    logic [TAG_WIDTH-1:0]    w_tag;
    logic [INDEX_WIDTH-1:0]  w_idx;
    logic [OFFSET_WIDTH-1:0] w_off;
    logic                    w_hit0;
    logic                    w_hit1;
    logic                    w_hit;
    logic                    w_hit_way;
    logic                    w_victim;
    logic                    w_victim_dirty;
    logic [TAG_WIDTH-1:0]    w_victim_tag;
    logic                    w_beat_last;

    assign w_tag     = r_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_idx     = r_req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_off     = r_req_addr[OFFSET_WIDTH-1:0];
    assign w_hit0    = valid0 && (tagout0 == w_tag);
    assign w_hit1    = valid1 && (tagout1 == w_tag);
    assign w_hit     = w_hit0 || w_hit1;
    assign w_hit_way = !w_hit0;

    // Fill an empty way first; only fall back to LRU when both ways hold lines.
    assign w_victim       = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : r_lru[w_idx]);
    assign w_victim_dirty = w_victim ? (valid1 && dirty1) : (valid0 && dirty0);
    assign w_victim_tag   = r_victim ? tagout1 : tagout0;
    assign w_beat_last    = mem_ready && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (cpu_rd || cpu_wr) w_state_nxt = c_LOOKUP;
            c_LOOKUP: begin
                if (w_hit)               w_state_nxt = c_IDLE;
                else if (w_victim_dirty) w_state_nxt = c_WB;
                else                     w_state_nxt = c_REFILL;
            end
            c_WB:     if (w_beat_last) w_state_nxt = c_REFILL;
            c_REFILL: if (w_beat_last) w_state_nxt = c_UPDATE;
            c_UPDATE: w_state_nxt = c_LOOKUP;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_addr <= '0;
            r_req_wr   <= 1'b0;
            r_victim   <= 1'b0;
            r_cnt      <= '0;
            r_lru      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cpu_rd || cpu_wr) begin
                        r_req_addr <= cpu_addr;
                        r_req_wr   <= cpu_wr;
                    end
                end
                c_LOOKUP: begin
                    if (w_hit) begin
                        r_lru[w_idx] <= ~w_hit_way;
                    end else begin
                        r_victim <= w_victim;
                        r_cnt    <= '0;
                    end
                end
                c_WB, c_REFILL: begin
                    if (mem_ready) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_ready   = 1'b0;
        tag_rd      = 1'b0;
        tag_wr      = 2'b00;
        tag_index   = '0;
        tag_in      = '0;
        dirty_wr    = 1'b0;
        data_way    = 1'b0;
        data_offset = '0;
        data_wr     = 1'b0;
        data_src    = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        if (r_state != c_IDLE) tag_index = w_idx;
        case (r_state)
            c_LOOKUP: begin
                tag_rd = 1'b1;
                if (w_hit) begin
                    cpu_ready   = 1'b1;
                    data_way    = w_hit_way;
                    data_offset = w_off;
                    if (r_req_wr) begin
                        data_wr           = 1'b1;
                        tag_wr[w_hit_way] = 1'b1;
                        tag_in            = w_tag;
                        dirty_wr          = 1'b1;
                    end
                end
            end
            c_WB: begin
                mem_wr      = 1'b1;
                mem_addr    = {w_victim_tag, w_idx, r_cnt};
                data_way    = r_victim;
                data_offset = r_cnt;
            end
            c_REFILL: begin
                mem_rd      = 1'b1;
                mem_addr    = {w_tag, w_idx, r_cnt};
                data_way    = r_victim;
                data_offset = r_cnt;
                data_src    = 1'b1;
                data_wr     = mem_ready;
            end
            c_UPDATE: begin
                tag_wr[r_victim] = 1'b1;
                tag_in           = w_tag;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
